// File: rtl/phase_interp_pkg.sv
// Shared definitions for the phase interpolator controller.
//   pi_state_t         : controller FSM states (IDLE / SLEW / SETTLE)
//   HALF_TURN_POSITIVE : direction chosen when the target is exactly half a
//                        turn away (1 = step upwards, 0 = step downwards)
package phase_interp_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SLEW   = 2'd1,
        SETTLE = 2'd2
    } pi_state_t;

    localparam logic HALF_TURN_POSITIVE = 1'b1;

endpackage

// File: rtl/pi_slew_step.sv
// One slew step of the phase code toward a target along the shortest path
// around the circle of 2^CODE_W codes. Purely combinational.
//   cur    : current applied phase code
//   target : requested phase code
//   next   : code to apply on the next cycle (target itself once within reach)
//   done   : target is within MAX_STEP of cur, so next == target
module pi_slew_step
    import phase_interp_pkg::*;
#(
    parameter int CODE_W   = 9,
    parameter int MAX_STEP = 4
) (
    input  logic [CODE_W-1:0] cur,
    input  logic [CODE_W-1:0] target,
    output logic [CODE_W-1:0] next,
    output logic              done
);

    localparam logic [CODE_W-1:0] STEP    = CODE_W'(MAX_STEP);
    localparam logic [CODE_W:0]   MAX_MAG = (CODE_W+1)'(MAX_STEP);
    localparam logic [CODE_W-1:0] HALF    = {1'b1, {(CODE_W-1){1'b0}}};

    logic [CODE_W-1:0] diff;
    logic [CODE_W:0]   diff_ext;
    logic [CODE_W:0]   mag;
    logic              go_down;

    always_comb begin
        // Modular difference, read as a signed CODE_W-bit value.
        diff     = target - cur;
        // One extra bit so the magnitude of the most negative value fits.
        diff_ext = {diff[CODE_W-1], diff};
        mag      = diff_ext[CODE_W] ? -diff_ext : diff_ext;
        // Exact half turn is ambiguous; the package constant picks a side.
        go_down  = diff[CODE_W-1] && !((diff == HALF) && HALF_TURN_POSITIVE);
        done     = (mag <= MAX_MAG);
        if (done) begin
            next = target;
        end else if (go_down) begin
            next = cur - STEP;
        end else begin
            next = cur + STEP;
        end
    end

endmodule

// File: rtl/phase_interpolator_ctrl.sv
// Phase interpolator controller: a phase accumulator plus a slew-limited
// phase offset produce NUM_CLK equally spaced recovered clocks, with two
// divide-by-2 clocks derived from the edges of recovered_clock[0].
//   clk, rst_n        : sole clock, asynchronous active-low reset
//   enable            : advance the accumulator by freq_word each clk
//   freq_word         : accumulator increment
//   phase_shift/_valid/_ready : target code handshake; a target is taken on a
//                       clk edge where valid and ready are both high. ready is
//                       high only while idle; valid offered at other times is
//                       dropped, not queued.
//   phase_code        : currently applied code
//   locked            : applied code equals target and settling is over
//   recovered_clock   : interpolated clocks, registered
//   data_clock        : toggles after each rising edge of recovered_clock[0]
//   phase_clock       : toggles after each falling edge of recovered_clock[0]
module phase_interpolator_ctrl
    import phase_interp_pkg::*;
#(
    parameter int FINE_BITS  = 7,
    parameter int CODE_W     = FINE_BITS + 2,
    parameter int NUM_CLK    = 4,
    parameter int MAX_STEP   = 4,
    parameter int SETTLE_CYC = 8
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               enable,
    input  logic [CODE_W-1:0]  freq_word,
    input  logic [CODE_W-1:0]  phase_shift,
    input  logic               phase_shift_valid,
    output logic               phase_shift_ready,
    output logic [CODE_W-1:0]  phase_code,
    output logic               locked,
    output logic [NUM_CLK-1:0] recovered_clock,
    output logic               data_clock,
    output logic               phase_clock
);

    localparam int SW      = (SETTLE_CYC > 1) ? $clog2(SETTLE_CYC) : 1;
    localparam int SPACING = (2 ** CODE_W) / NUM_CLK;
    localparam logic [SW-1:0] SETTLE_LAST = SW'(SETTLE_CYC - 1);

    pi_state_t         state, state_next;
    logic [SW-1:0]     cnt, cnt_next;
    logic [CODE_W-1:0] acc;
    logic [CODE_W-1:0] cur_code, code_next;
    logic [CODE_W-1:0] target, target_next;
    logic [CODE_W-1:0] step_next;
    logic              step_done;
    logic              ready_q;
    logic              locked_q;
    logic              rc0_prev;
    logic [NUM_CLK-1:0] rc_next;

    function automatic logic phase_msb(input logic [CODE_W-1:0] a,
                                       input logic [CODE_W-1:0] b,
                                       input logic [CODE_W-1:0] c);
        logic [CODE_W-1:0] s;
        s = a + b + c;
        return s[CODE_W-1];
    endfunction

    pi_slew_step #(
        .CODE_W   (CODE_W),
        .MAX_STEP (MAX_STEP)
    ) u_step (
        .cur    (cur_code),
        .target (target),
        .next   (step_next),
        .done   (step_done)
    );

    // Next-state and datapath control.
    always_comb begin
        state_next  = state;
        cnt_next    = cnt;
        target_next = target;
        code_next   = cur_code;
        case (state)
            IDLE: begin
                if (phase_shift_valid && ready_q) begin
                    target_next = phase_shift;
                    cnt_next    = '0;
                    state_next  = (phase_shift == cur_code) ? SETTLE : SLEW;
                end
            end
            SLEW: begin
                code_next = step_next;
                if (step_done) begin
                    cnt_next   = '0;
                    state_next = SETTLE;
                end
            end
            SETTLE: begin
                if (cnt == SETTLE_LAST) begin
                    cnt_next   = '0;
                    state_next = IDLE;
                end else begin
                    cnt_next = cnt + SW'(1);
                end
            end
            default: begin
                state_next = IDLE;
                cnt_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            cnt      <= '0;
            target   <= '0;
            cur_code <= '0;
            ready_q  <= 1'b0;
            locked_q <= 1'b0;
        end else begin
            state    <= state_next;
            cnt      <= cnt_next;
            target   <= target_next;
            cur_code <= code_next;
            // Both flags track "FSM is idle", but stay low while in reset.
            ready_q  <= (state_next == IDLE);
            locked_q <= (state_next == IDLE);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc <= '0;
        end else if (enable) begin
            acc <= acc + freq_word;
        end
    end

    // Each output clock is the MSB of accumulator + code + its fixed offset.
    for (genvar k = 0; k < NUM_CLK; k++) begin : g_rc
        assign rc_next[k] = phase_msb(acc, cur_code, CODE_W'(k * SPACING));
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            recovered_clock <= '0;
            rc0_prev        <= 1'b0;
            data_clock      <= 1'b0;
            phase_clock     <= 1'b0;
        end else begin
            recovered_clock <= rc_next;
            rc0_prev        <= recovered_clock[0];
            if (recovered_clock[0] && !rc0_prev) begin
                data_clock <= ~data_clock;
            end
            if (!recovered_clock[0] && rc0_prev) begin
                phase_clock <= ~phase_clock;
            end
        end
    end

    assign phase_shift_ready = ready_q;
    assign locked            = locked_q;
    assign phase_code        = cur_code;

endmodule

// File: doc/phase_interpolator_ctrl.md
PHASE_INTERPOLATOR_CTRL -- requirements
Module: phase_interpolator_ctrl

Interface
REQ-001 SHALL have parameter FINE_BITS, default 7, meaning fine interpolation bits per quadrant.
REQ-002 SHALL have parameter CODE_W, default FINE_BITS+2, meaning phase code width (2 quadrant bits plus fine bits; one turn = 2^CODE_W codes).
REQ-003 SHALL have parameter NUM_CLK, default 4, meaning number of equally spaced recovered clock outputs (power of 2, at least 1, at most 2^CODE_W).
REQ-004 SHALL have parameter MAX_STEP, default 4, meaning maximum phase code change per clk cycle (at least 1).
REQ-005 SHALL have parameter SETTLE_CYC, default 8, meaning hold cycles after the slew finishes (at least 1).
REQ-006 SHALL have port clk, input, 1 bit, meaning sampling clock and sole clock.
REQ-007 SHALL have port rst_n, input, 1 bit, meaning asynchronous active-low reset.
REQ-008 SHALL have port enable, input, 1 bit, meaning advance the phase accumulator.
REQ-009 SHALL have port freq_word, input, CODE_W bits, meaning accumulator increment per clk.
REQ-010 SHALL have port phase_shift, input, CODE_W bits, meaning target phase code.
REQ-011 SHALL have port phase_shift_valid, input, 1 bit, meaning phase_shift is offered.
REQ-012 SHALL have port phase_shift_ready, output, 1 bit, meaning a new target can be accepted.
REQ-013 SHALL have port phase_code, output, CODE_W bits, meaning current applied code.
REQ-014 SHALL have port locked, output, 1 bit, meaning phase_code equals target and settle is complete.
REQ-015 SHALL have port recovered_clock, output, NUM_CLK bits, meaning interpolated clocks.
REQ-016 SHALL have port data_clock, output, 1 bit, meaning divide-by-2 toggle on rising recovered_clock[0].
REQ-017 SHALL have port phase_clock, output, 1 bit, meaning divide-by-2 toggle on falling recovered_clock[0].

Function
REQ-018 SHALL implement an FSM with states IDLE, SLEW and SETTLE; phase_shift_ready SHALL be 1 only in IDLE.
REQ-019 SHALL accept a target on a clk edge with valid and ready both high; the FSM SHALL then go to SLEW, or directly to SETTLE if the target equals cur_code.
REQ-020 SHALL ignore phase_shift_valid outside IDLE; no request is queued.
REQ-021 SHALL, in SLEW, compute diff = (target - cur_code) mod 2^CODE_W, interpreted as signed CODE_W.
REQ-022 SHALL, when |diff| <= MAX_STEP, set cur_code to target and go to SETTLE; otherwise cur_code SHALL move MAX_STEP toward target along the shortest path, modulo 2^CODE_W.
REQ-023 SHALL resolve diff = -2^(CODE_W-1) (exact half turn) in the positive direction.
REQ-024 SHALL wrap cur_code modulo 2^CODE_W, with no saturation.
REQ-025 SHALL count SETTLE_CYC cycles in SETTLE and then go to IDLE.
REQ-026 SHALL assert locked, registered, in IDLE only.
REQ-027 SHALL make phase_code a direct view of cur_code.
REQ-028 SHALL update acc to (acc + freq_word) mod 2^CODE_W on each clk with enable = 1, and hold acc when enable = 0.
REQ-029 SHALL continue slewing independent of enable.
REQ-030 SHALL register recovered_clock[k] as the MSB of (acc + cur_code + k*2^CODE_W/NUM_CLK) mod 2^CODE_W, one cycle latency from acc and cur_code.
REQ-031 SHALL detect edges of recovered_clock[0] with a registered previous value.
REQ-032 SHALL toggle data_clock in the cycle after a 0->1 edge of recovered_clock[0], and toggle phase_clock in the cycle after a 1->0 edge.

Reset
REQ-033 SHALL, on rst_n low asynchronously, force:
- acc = 0, cur_code = 0, target = 0;
- FSM = IDLE, settle counter = 0;
- recovered_clock = 0, edge history = 0;
- data_clock = 0, phase_clock = 0, locked = 0.
REQ-034 SHALL, after rst_n deasserts, assert locked and phase_shift_ready from the first clk edge.
REQ-035 SHALL abandon any slew or settle in progress when reset is asserted mid-operation, with no residual state.

Structure
REQ-036 SHALL place the FSM state enum (pi_state_t) and the half-turn tie-break constant in package phase_interp_pkg.
REQ-037 SHALL implement the signed shortest-path step computation in sub-module pi_slew_step, which is purely combinational (cur, target -> next).
REQ-038 SHALL be synthesisable, with no real types or $sin.

Verification
REQ-039 SHALL cover basic clocking: defaults, freq_word = 32, target 0, enable = 1 -> recovered_clock[0] has period 16 clk, 50% duty; data_clock and phase_clock have period 32 clk, offset 8 clk.
REQ-040 SHALL cover a small step: accept target 3 from cur 0 -> phase_code 3 after 1 cycle; locked returns 8 cycles later.
REQ-041 SHALL cover a large slew: target 20 from cur 0 -> phase_code 4, 8, 12, 16, 20 on successive cycles; ready stays low throughout slew and settle.
REQ-042 SHALL cover wrap-around: cur 2, target 510 -> steps go negative 2 -> 510 in 1 cycle (diff -4); cur 508, target 4 -> 512 wraps to 0, then 4.
REQ-043 SHALL cover the half-turn tie: cur 0, target 256 -> increments of +4, 64 steps.
REQ-044 SHALL cover ignored requests and mid-operation reset:
- valid pulsed during SLEW is ignored;
- rst_n low mid-slew -> all outputs 0 immediately; ready = 1 at the first edge after release.
